// File: rtl/trigger_cmd_queue.sv
// Captures Trigger In pulses as sticky pending requests and issues them round-robin as
// command IDs over valid/ready; repeat triggers on a pending bit are logged as overruns.
module trigger_cmd_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ID_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             ep_clk,
    input  logic             ep_reset,
    input  logic [WIDTH-1:0] ep_trigger,
    input  logic [WIDTH-1:0] trig_enable,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [ID_W-1:0]  cmd_id,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overrun_flags,
    output logic [CNT_W-1:0] overrun_count,
    input  logic             clear_overrun,
    output logic             busy
);

    // Wide enough to add a full-width popcount to a saturated counter without wrapping.
    localparam int unsigned SumW = CNT_W + ID_W + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ID_W-1:0]  cmd_id_q, cmd_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0] trig_q;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] overrun;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic             grant_en;
    logic [SumW-1:0]  ov_pop;
    logic [SumW-1:0]  cnt_sum;
    logic [CNT_W-1:0] cnt_base;

    assign trig_q = ep_trigger & trig_enable;

    // First set pending bit at or above rr_ptr, wrapping from WIDTH-1 back to 0.
    always_comb begin
        int unsigned j;
        logic [ID_W-1:0] j_idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        j_idx     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            j_idx = ID_W'(j);
            if (!gnt_found && pending_q[j_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = j_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    grant_en = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (cmd_ready) begin
                    if (gnt_found) begin
                        grant_en = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        cmd_id_d = cmd_id_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_en) begin
            clr_mask = WIDTH'(1) << gnt_idx;
            cmd_id_d = gnt_idx;
            rr_ptr_d = (gnt_idx == ID_W'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // A trigger landing on the bit granted this cycle becomes a fresh request, not an overrun.
    assign overrun   = trig_q & pending_q & ~clr_mask;
    assign pending_d = (pending_q & ~clr_mask) | trig_q;

    always_comb begin
        ov_pop = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            ov_pop = ov_pop + SumW'(overrun[k]);
        end
        cnt_base = clear_overrun ? '0 : count_q;
        cnt_sum  = SumW'(cnt_base) + ov_pop;
        count_d  = (cnt_sum > SumW'(CntMax)) ? CntMax : cnt_sum[CNT_W-1:0];
        flags_d  = (clear_overrun ? '0 : flags_q) | overrun;
    end

    always_ff @(posedge ep_clk) begin
        if (ep_reset) begin
            state_q   <= StIdle;
            pending_q <= '0;
            flags_q   <= '0;
            count_q   <= '0;
            cmd_id_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            flags_q   <= flags_d;
            count_q   <= count_d;
            cmd_id_q  <= cmd_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign cmd_valid     = (state_q == StIssue);
    assign cmd_id        = cmd_id_q;
    assign pending       = pending_q;
    assign overrun_flags = flags_q;
    assign overrun_count = count_q;
    assign busy          = (state_q == StIssue) | (|pending_q);

endmodule

// File: tb/tb_trigger_cmd_queue.sv
// Bench for trigger_cmd_queue: directed vector table, saturation/clear sequence, then random
// stimulus checked against a queue-level reference model.
module tb_trigger_cmd_queue;

    logic        ep_clk;
    logic        ep_reset;
    logic [31:0] ep_trigger;
    logic [31:0] trig_enable;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_id;
    logic [31:0] pending;
    logic [31:0] overrun_flags;
    logic [15:0] overrun_count;
    logic        clear_overrun;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] m_pending;
    logic [31:0] m_flags;
    bit          m_valid;
    int unsigned m_id;
    int unsigned m_rr;
    int unsigned m_count;

    typedef struct {
        bit          rst;
        logic [31:0] trig;
        logic [31:0] en;
        bit          rdy;
        bit          clr;
        bit          v;
        logic [4:0]  id;
        logic [31:0] p;
        logic [31:0] f;
        logic [15:0] c;
    } vec_t;

    vec_t vecs[32];

    trigger_cmd_queue #(
        .WIDTH (32),
        .ID_W  (5),
        .CNT_W (16)
    ) dut (
        .ep_clk        (ep_clk),
        .ep_reset      (ep_reset),
        .ep_trigger    (ep_trigger),
        .trig_enable   (trig_enable),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_id        (cmd_id),
        .pending       (pending),
        .overrun_flags (overrun_flags),
        .overrun_count (overrun_count),
        .clear_overrun (clear_overrun),
        .busy          (busy)
    );

    initial begin
        ep_clk = 1'b0;
        forever #5 ep_clk = ~ep_clk;
    end

    function automatic void model_step(bit rst, logic [31:0] trig, logic [31:0] en, bit rdy,
                                       bit clr);
        logic [31:0] t;
        logic [31:0] gmask;
        logic [31:0] ov;
        bit          grant;
        bit          found;
        int unsigned g;
        int unsigned total;
        if (rst) begin
            m_pending = '0;
            m_flags   = '0;
            m_valid   = 1'b0;
            m_id      = 0;
            m_rr      = 0;
            m_count   = 0;
            return;
        end
        t     = trig & en;
        grant = (!m_valid || rdy) && (m_pending != 0);
        gmask = '0;
        g     = 0;
        found = 1'b0;
        if (grant) begin
            for (int i = 0; i < 32; i++) begin
                int unsigned j;
                j = (m_rr + i) % 32;
                if (!found && ((m_pending >> j) & 32'h1) != 0) begin
                    found = 1'b1;
                    g     = j;
                end
            end
            gmask = 32'h1 << g;
        end
        ov      = t & m_pending & ~gmask;
        total   = (clr ? 0 : m_count) + $countones(ov);
        m_count = (total > 65535) ? 65535 : total;
        m_flags = (clr ? 32'h0 : m_flags) | ov;
        m_pending = (m_pending & ~gmask) | t;
        if (grant) begin
            m_valid = 1'b1;
            m_id    = g;
            m_rr    = (g + 1) % 32;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic step(bit rst, logic [31:0] trig, logic [31:0] en, bit rdy, bit clr);
        ep_reset      = rst;
        ep_trigger    = trig;
        trig_enable   = en;
        cmd_ready     = rdy;
        clear_overrun = clr;
        @(posedge ep_clk);
        model_step(rst, trig, en, rdy, clr);
        #1;
    endtask

    task automatic check_exp(string name, bit v, logic [4:0] id, logic [31:0] p, logic [31:0] f,
                             logic [15:0] c);
        bit b;
        b = v | (|p);
        n_tests++;
        if (cmd_valid !== v || (v && cmd_id !== id) || pending !== p || overrun_flags !== f ||
            overrun_count !== c || busy !== b) begin
            n_fail++;
            $display("FAIL %s: got valid=%b id=%0d pend=%h flags=%h cnt=%h busy=%b; want valid=%b id=%0d pend=%h flags=%h cnt=%h busy=%b",
                     name, cmd_valid, cmd_id, pending, overrun_flags, overrun_count, busy,
                     v, id, p, f, c, b);
        end
    endtask

    task automatic check_model(string name);
        check_exp(name, m_valid, 5'(m_id), m_pending, m_flags, 16'(m_count));
    endtask

    initial begin
        logic [31:0] rt;
        logic [31:0] ren;
        ep_reset      = 1'b1;
        ep_trigger    = '0;
        trig_enable   = '0;
        cmd_ready     = 1'b0;
        clear_overrun = 1'b0;

        //           rst trig          en            rdy clr  v  id  pend          flags  cnt
        vecs[0]  = '{1, 32'h0,        32'hFFFFFFFF, 1, 0,  0, 0,  32'h0,        32'h0, 16'd0};
        vecs[1]  = '{0, 32'h8,        32'hFFFFFFFF, 1, 0,  0, 0,  32'h8,        32'h0, 16'd0};
        vecs[2]  = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  1, 3,  32'h0,        32'h0, 16'd0};
        vecs[3]  = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  0, 0,  32'h0,        32'h0, 16'd0};
        vecs[4]  = '{0, 32'hFFFF0000, 32'h0000FFFF, 1, 0,  0, 0,  32'h0,        32'h0, 16'd0};
        vecs[5]  = '{0, 32'h0,        32'h0000FFFF, 1, 0,  0, 0,  32'h0,        32'h0, 16'd0};
        vecs[6]  = '{1, 32'h0,        32'hFFFFFFFF, 0, 0,  0, 0,  32'h0,        32'h0, 16'd0};
        vecs[7]  = '{0, 32'h80000001, 32'hFFFFFFFF, 0, 0,  0, 0,  32'h80000001, 32'h0, 16'd0};
        vecs[8]  = '{0, 32'h0,        32'hFFFFFFFF, 0, 0,  1, 0,  32'h80000000, 32'h0, 16'd0};
        vecs[9]  = '{0, 32'h1,        32'hFFFFFFFF, 0, 0,  1, 0,  32'h80000001, 32'h0, 16'd0};
        vecs[10] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  1, 31, 32'h1,        32'h0, 16'd0};
        vecs[11] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  1, 0,  32'h0,        32'h0, 16'd0};
        vecs[12] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  0, 0,  32'h0,        32'h0, 16'd0};
        vecs[13] = '{0, 32'h10,       32'hFFFFFFFF, 1, 0,  0, 0,  32'h10,       32'h0, 16'd0};
        vecs[14] = '{0, 32'h10,       32'hFFFFFFFF, 1, 0,  1, 4,  32'h10,       32'h0, 16'd0};
        vecs[15] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  1, 4,  32'h0,        32'h0, 16'd0};
        vecs[16] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  0, 0,  32'h0,        32'h0, 16'd0};
        vecs[17] = '{0, 32'h20,       32'hFFFFFFFF, 0, 0,  0, 0,  32'h20,       32'h0, 16'd0};
        vecs[18] = '{0, 32'h80,       32'hFFFFFFFF, 0, 0,  1, 5,  32'h80,       32'h0, 16'd0};
        vecs[19] = '{0, 32'h80,       32'hFFFFFFFF, 0, 0,  1, 5,  32'h80,       32'h80, 16'd1};
        vecs[20] = '{0, 32'h80,       32'hFFFFFFFF, 0, 0,  1, 5,  32'h80,       32'h80, 16'd2};
        vecs[21] = '{0, 32'h4,        32'hFFFFFFFF, 0, 0,  1, 5,  32'h84,       32'h80, 16'd2};
        vecs[22] = '{0, 32'h4,        32'hFFFFFFFF, 0, 1,  1, 5,  32'h84,       32'h4, 16'd1};
        vecs[23] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  1, 7,  32'h4,        32'h4, 16'd1};
        vecs[24] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  1, 2,  32'h0,        32'h4, 16'd1};
        vecs[25] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  0, 0,  32'h0,        32'h4, 16'd1};
        vecs[26] = '{0, 32'h1E00,     32'hFFFFFFFF, 0, 0,  0, 0,  32'h1E00,     32'h4, 16'd1};
        vecs[27] = '{0, 32'h0,        32'hFFFFFFFF, 0, 0,  1, 9,  32'h1C00,     32'h4, 16'd1};
        vecs[28] = '{1, 32'h0,        32'hFFFFFFFF, 0, 0,  0, 0,  32'h0,        32'h0, 16'd0};
        vecs[29] = '{0, 32'h200,      32'hFFFFFFFF, 1, 0,  0, 0,  32'h200,      32'h0, 16'd0};
        vecs[30] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  1, 9,  32'h0,        32'h0, 16'd0};
        vecs[31] = '{0, 32'h0,        32'hFFFFFFFF, 1, 0,  0, 0,  32'h0,        32'h0, 16'd0};

        for (int i = 0; i < 32; i++) begin
            step(vecs[i].rst, vecs[i].trig, vecs[i].en, vecs[i].rdy, vecs[i].clr);
            check_exp($sformatf("vec%0d", i), vecs[i].v, vecs[i].id, vecs[i].p, vecs[i].f,
                      vecs[i].c);
        end

        // Saturation: all bits pending, command stalled, every bit re-triggered each cycle.
        step(1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        check_model("sat_reset");
        for (int i = 0; i < 2200; i++) begin
            step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
            check_model("sat_run");
        end
        check_exp("sat_hold", 1'b1, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF);
        step(1'b0, 32'h4, 32'hFFFFFFFF, 1'b0, 1'b1);
        check_exp("clear_with_overrun", 1'b1, 5'd0, 32'hFFFFFFFF, 32'h4, 16'd1);

        // Randomized traffic against the reference model.
        step(1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        check_model("rand_reset");
        for (int i = 0; i < 3000; i++) begin
            rt  = $urandom & $urandom & $urandom;
            ren = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFFFFFF;
            step(($urandom_range(0, 499) == 0), rt, ren, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_cmd_queue.md
# trigger_cmd_queue

Captures the one-cycle trigger pulses produced by the Trigger In endpoint on `ep_clk`. Holds each trigger bit as a sticky pending request and issues the requests one at a time, in round-robin order, as command IDs over a valid/ready handshake to the acquisition/DDR2 control logic. Triggers that arrive while the same bit is still pending are recorded as overruns: a sticky per-bit flag plus a saturating counter, both readable by the host through a Wire Out.

## Interface
- `WIDTH`, default 32: number of trigger bits; matches the endpoint's 32-bit trigger vector.
- `ID_W`, default 5: command ID width; equals clog2(`WIDTH`).
- `CNT_W`, default 16: overrun counter width.

- `ep_clk`  in  1: sole clock; same clock as the Trigger In endpoint's `ep_clk`.
- `ep_reset`  in  1: reset, synchronous to `ep_clk`, active-high.
- `ep_trigger`  in  `WIDTH`: trigger vector from the Trigger In endpoint; each bit is a single-cycle pulse.
- `trig_enable`  in  `WIDTH`: per-bit enable; 0 means that bit's trigger is ignored.
- `cmd_valid`  out  1: a command is offered.
- `cmd_ready`  in  1: downstream accepts the command.
- `cmd_id`  out  `ID_W`: index of the trigger bit being issued.
- `pending`  out  `WIDTH`: pending request register.
- `overrun_flags`  out  `WIDTH`: sticky per-bit overrun flags.
- `overrun_count`  out  `CNT_W`: saturating count of overrun events.
- `clear_overrun`  in  1: single-cycle pulse that clears `overrun_flags` and `overrun_count`.
- `busy`  out  1: equals `cmd_valid | (|pending)`.

## Operation
- **Qualified trigger:** `t = ep_trigger & trig_enable`. Disabled bits never set `pending` and never count as overruns.
- **State machine:** two states, IDLE and ISSUE; `cmd_valid` = (state == ISSUE).
- **IDLE:**
  - If `pending != 0`: grant bit g, the first set bit searching upward from `rr_ptr` with wrap from `WIDTH-1` to 0.
  - Load `cmd_id = g`, clear `pending[g]`, set `rr_ptr = (g+1) mod WIDTH`, go to ISSUE.
- **ISSUE:**
  - `cmd_id` is held stable until `cmd_ready = 1`.
  - On handshake, if `pending != 0`, grant the next bit in the same cycle and remain in ISSUE (back-to-back issue).
  - On handshake with `pending == 0`, go to IDLE.
- **Pending update (per bit k, each cycle):** `pending[k]_next = (pending[k] & ~clr[k]) | t[k]`, where `clr` is the one-hot grant.
- **Overrun (bit k):** `t[k] = 1` while `pending[k] = 1` and k is not being granted this cycle.
  - Sets `overrun_flags[k]`.
  - Adds 1 to `overrun_count`, saturating at 2^`CNT_W`-1.
  - If several bits overrun in one cycle, the count increases by 1 per bit (popcount), still saturating.
- **Cases that are not overruns:**
  - `t[k]` arriving in the same cycle `pending[k]` is granted: `pending[k]` stays 1 as a new request.
  - `t[k]` while command k is in flight (`cmd_valid = 1`, `cmd_id = k`): `pending[k]` sets normally.
- **`clear_overrun`:** clears flags and counter. An overrun in the same cycle wins: that flag ends set and the counter ends equal to that cycle's overrun count.
- **`trig_enable` changes:** affect only new triggers. Already-pending bits are still issued.

## Timing
- **Reset:** all of the following are 0 one cycle after `ep_reset` is sampled high: `cmd_valid`, `cmd_id`, `pending`, `overrun_flags`, `overrun_count`, `rr_ptr`, `busy`; state = IDLE.
- **Reset mid-operation:** an in-flight command is dropped without handshake, and pending requests are lost.
- **Latency:** a trigger sampled at edge N gives `pending` set after N. The command `cmd_valid = 1` appears after edge N+1 if the block is idle. Trigger to valid is 2 cycles.
- **Throughput:** 1 command per cycle while `cmd_ready` stays high and `pending` is non-zero.
- **Output stability:** `cmd_valid` never deasserts and `cmd_id` never changes without a handshake (except on reset).
- **Registers:** all outputs are registered. There is no combinational path from `cmd_ready` to `cmd_valid`/`cmd_id`.

## Test plan
- **Single trigger:** reset; `trig_enable` = FFFFFFFF; `ep_trigger` = 00000008 for 1 cycle; `cmd_ready` = 1 -> `cmd_valid` high 2 cycles later for exactly 1 cycle with `cmd_id` = 3; `pending` returns to 0; `busy` falls.
- **Round-robin order:** with `cmd_ready` = 0, pulse 80000001; then after the first grant (`cmd_id` = 0) pulse 00000001 again; release `cmd_ready` -> order is 0, 31, 0; `rr_ptr` wraps correctly.
- **Overrun and saturation:** `cmd_ready` = 0 holding `cmd_id` 5; pulse bit 7 three times -> `pending[7]` = 1, `overrun_flags` = 00000080, `overrun_count` = 2. Force 70000 overruns -> count holds at FFFF. Pulse `clear_overrun` together with an overrun on bit 2 -> flags = 00000004, count = 1.
- **Same-cycle grant and trigger:** bit 4 pending and granted in cycle N with `t[4]` = 1 in cycle N -> no overrun; `cmd_id` 4 is issued twice.
- **Masking:** `trig_enable` = 0000FFFF; pulse FFFF0000 -> no `pending`, no `cmd_valid`, no overrun.
- **Reset mid-operation:** with `cmd_valid` = 1 and 3 bits pending, assert `ep_reset` for 1 cycle -> all outputs 0 next cycle; a subsequent trigger on bit 9 is issued as `cmd_id` 9, with the search starting from `rr_ptr` = 0.
